morty_ex_muldiv: RTL
====================

# morty_ex_muldiv

Multi-cycle RV32M multiply/divide unit in the Morty execute stage, directly downstream of the ID/EX pipeline register. It takes `ex_porta` and `ex_portb` plus an M-extension op from ID/EX and computes the result. While busy it asserts a stall that freezes ID/EX and everything upstream. It presents the result to the EX result mux with a one-cycle valid pulse.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of the in-flight op (trap/redirect).
- `ex_start`  in  1  the ID/EX instruction is an M-extension op; held high while ID/EX is stalled.
- `ex_muldiv_op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `ex_porta`  in  32  rs1 operand (dividend/multiplicand).
- `ex_portb`  in  32  rs2 operand (divisor/multiplier).
- `muldiv_result`  out  32  result, stable from DONE until the next DONE.
- `muldiv_valid`  out  1  one-cycle pulse; `muldiv_result` is valid for the instruction in EX.
- `muldiv_stall`  out  1  holds ID/EX and upstream stages.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE with `ex_start`=1: latch the op, the operand magnitudes and the result sign, then go to BUSY.
  - MULHSU treats only `ex_porta` as signed.
  - MULHU and DIVU/REMU treat both operands as unsigned.
- IDLE special cases go straight to DONE with no BUSY cycles:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `ex_porta`.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- BUSY, multiply: radix-2 shift-add on a 64-bit accumulator, 32 iterations. The 6-bit counter runs 0..31, then the FSM goes to DONE.
- BUSY, divide: restoring divide, 32 iterations, 32-bit quotient and remainder.
- Sign fixup happens in the BUSY→DONE transition.
  - Product: negated if the operand signs differ.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the sign of the dividend.
- Result selection:
  - MUL: low word of the product.
  - MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: register `muldiv_result`, assert `muldiv_valid`, then go to IDLE. `ex_start` is ignored in DONE because it still reflects the retiring instruction.
- `muldiv_stall` = (IDLE & `ex_start` & !`flush`) | BUSY. It is combinational and forced 0 while `rst` is low.
- `flush` overrides everything: from any state go to IDLE, no valid pulse, counter cleared.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `muldiv_result` 0x00000000, `muldiv_valid` 0, `muldiv_stall` 0.
- Reset asserted mid-operation aborts immediately (asynchronous); no valid pulse follows.
- Iterative op, `ex_start` first seen in cycle T:
  - Stall is high in T through T+32 (IDLE, then BUSY).
  - DONE is in T+33: valid=1 and stall=0. ID/EX advances at the end of T+33.
- Special-case divide: stall high in T, DONE in T+1.
- Back-to-back M ops: the second op is sampled in IDLE at T+34. There is no dead cycle beyond DONE.
- `flush` and `ex_start` in the same cycle: `flush` wins and the op is not started.

## Configuration
- `MORTY_MULDIV_FAST_MUL_EN` defined: all four multiply ops use a single-cycle 33x33 signed multiplier.
  - IDLE→DONE directly; stall high 1 cycle; valid at T+1.
  - Divides are unchanged.
- Macro undefined: multiplies use the 32-iteration BUSY path; no hardware multiplier is inferred.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB. Valid at T+33 (T+1 with the macro); stall low in the valid cycle.
- High-word multiplies → results as listed, each with exactly one valid pulse:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divides → results as listed, valid at T+33:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special-case divides → results as listed, stall high 1 cycle, valid at T+1:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- `flush` at BUSY iteration 10 → no valid, stall 0 the next cycle, `muldiv_result` unchanged. A new DIVU 9/3 is then accepted and gives 3.
- `rst` low at BUSY iteration 5 → stall 0 and result 0x00000000 immediately. After release with `ex_start` low the unit stays IDLE; a fresh MUL 3 × 4 then gives 12.

Source files
------------

// File: rtl/morty_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : morty_ex_muldiv
// Description : Multi-cycle RV32M multiply/divide unit for the Morty execute
//               stage. Radix-2 shift-add multiply and restoring divide, 32
//               iterations each, with an early-out for divide-by-zero and
//               signed overflow. Stalls ID/EX while busy and signals
//               completion with a one-cycle valid pulse.
//               Optional build macro MORTY_MULDIV_FAST_MUL_EN replaces the
//               iterative multiply with a single-cycle 33x33 signed multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module morty_ex_muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        ex_start,
   input  logic [2:0]  ex_muldiv_op,
   input  logic [31:0] ex_porta,
   input  logic [31:0] ex_portb,
   output logic [31:0] muldiv_result,
   output logic        muldiv_valid,
   output logic        muldiv_stall
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] C_OP_MUL    = 3'd0;
   localparam logic [2:0] C_OP_MULH   = 3'd1;
   localparam logic [2:0] C_OP_MULHSU = 3'd2;
   localparam logic [2:0] C_OP_MULHU  = 3'd3;
   localparam logic [2:0] C_OP_DIV    = 3'd4;
   localparam logic [2:0] C_OP_DIVU   = 3'd5;
   localparam logic [2:0] C_OP_REM    = 3'd6;
   localparam logic [2:0] C_OP_REMU   = 3'd7;
   localparam logic [5:0] C_LAST_ITER = 6'd31;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_cnt, w_cnt_nxt;
   logic [63:0] r_acc, w_acc_nxt;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
   logic [31:0] r_opb, w_opb_nxt;     // mul: multiplicand magnitude; div: divisor magnitude
   logic [2:0]  r_op, w_op_nxt;
   logic        r_neg_q, w_neg_q_nxt; // negate product / quotient
   logic        r_neg_r, w_neg_r_nxt; // negate remainder
   logic [31:0] r_result, w_result_nxt;

   // Operand decode for the instruction presented by ID/EX
   logic        w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic        w_div_zero, w_div_ovf;
   logic [31:0] w_a_mag, w_b_mag;

   // One iteration of the selected algorithm plus sign fixup
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_step;
   logic [32:0] w_div_shift;
   logic        w_div_ge;
   logic [31:0] w_div_sub;
   logic [63:0] w_div_step, w_iter, w_prod;
   logic [31:0] w_quo, w_rem, w_final;

`ifdef MORTY_MULDIV_FAST_MUL_EN
   logic [63:0] w_fast_a, w_fast_b, w_fast_prod;
`endif

   assign w_is_div   = ex_muldiv_op[2];
   assign w_a_signed = ~ex_muldiv_op[0] | (ex_muldiv_op == C_OP_MULH);
   assign w_b_signed = (ex_muldiv_op == C_OP_MUL) | (ex_muldiv_op == C_OP_MULH) |
                       (ex_muldiv_op == C_OP_DIV) | (ex_muldiv_op == C_OP_REM);
   assign w_a_neg    = w_a_signed & ex_porta[31];
   assign w_b_neg    = w_b_signed & ex_portb[31];
   assign w_a_mag    = w_a_neg ? (32'd0 - ex_porta) : ex_porta;
   assign w_b_mag    = w_b_neg ? (32'd0 - ex_portb) : ex_portb;
   assign w_div_zero = w_is_div & (ex_portb == 32'd0);
   assign w_div_ovf  = w_is_div & ~ex_muldiv_op[0] &
                       (ex_porta == 32'h8000_0000) & (ex_portb == 32'hFFFF_FFFF);

   // Shift-add: conditionally add the multiplicand into the high half, shift right
   assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
   assign w_mul_step = {w_mul_sum, r_acc[31:1]};

   // Restoring divide: shift next dividend bit into the remainder, trial subtract
   assign w_div_shift = {r_acc[63:32], r_acc[31]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
   assign w_div_sub   = w_div_shift[31:0] - r_opb;
   assign w_div_step  = w_div_ge ? {w_div_sub, r_acc[30:0], 1'b1}
                                 : {w_div_shift[31:0], r_acc[30:0], 1'b0};

   assign w_iter = r_op[2] ? w_div_step : w_mul_step;
   assign w_prod = r_neg_q ? (64'd0 - w_iter) : w_iter;
   assign w_quo  = r_neg_q ? (32'd0 - w_iter[31:0]) : w_iter[31:0];
   assign w_rem  = r_neg_r ? (32'd0 - w_iter[63:32]) : w_iter[63:32];

`ifdef MORTY_MULDIV_FAST_MUL_EN
   // Sign-extended to 64 bits; the low 64 bits equal the 33x33 signed product
   assign w_fast_a    = {{32{w_a_neg}}, ex_porta};
   assign w_fast_b    = {{32{w_b_neg}}, ex_portb};
   assign w_fast_prod = w_fast_a * w_fast_b;
`endif

   // Final result word selection on the last iteration
   always_comb begin
      w_final = 32'd0;
      case (r_op)
         C_OP_MUL:                        w_final = w_prod[31:0];
         C_OP_MULH, C_OP_MULHSU, C_OP_MULHU: w_final = w_prod[63:32];
         C_OP_DIV, C_OP_DIVU:             w_final = w_quo;
         C_OP_REM, C_OP_REMU:             w_final = w_rem;
         default:                         w_final = 32'd0;
      endcase
   end

   // Next-state and datapath next values; flush overrides everything
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_acc_nxt    = r_acc;
      w_opb_nxt    = r_opb;
      w_op_nxt     = r_op;
      w_neg_q_nxt  = r_neg_q;
      w_neg_r_nxt  = r_neg_r;
      w_result_nxt = r_result;
      if (flush) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = 6'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ex_start) begin
                  w_op_nxt    = ex_muldiv_op;
                  w_neg_q_nxt = w_a_neg ^ w_b_neg;
                  w_neg_r_nxt = w_a_neg;
                  w_cnt_nxt   = 6'd0;
                  if (w_div_zero) begin
                     w_result_nxt = ex_muldiv_op[1] ? ex_porta : 32'hFFFF_FFFF;
                     w_state_nxt  = S_DONE;
                  end else if (w_div_ovf) begin
                     w_result_nxt = ex_muldiv_op[1] ? 32'd0 : 32'h8000_0000;
                     w_state_nxt  = S_DONE;
                  end
`ifdef MORTY_MULDIV_FAST_MUL_EN
                  else if (!w_is_div) begin
                     w_result_nxt = (ex_muldiv_op == C_OP_MUL) ? w_fast_prod[31:0]
                                                               : w_fast_prod[63:32];
                     w_state_nxt  = S_DONE;
                  end
`endif
                  else begin
                     w_state_nxt = S_BUSY;
                     if (w_is_div) begin
                        w_acc_nxt = {32'd0, w_a_mag};
                        w_opb_nxt = w_b_mag;
                     end else begin
                        w_acc_nxt = {32'd0, w_b_mag};
                        w_opb_nxt = w_a_mag;
                     end
                  end
               end
            end
            S_BUSY: begin
               w_acc_nxt = w_iter;
               if (r_cnt == C_LAST_ITER) begin
                  w_result_nxt = w_final;
                  w_cnt_nxt    = 6'd0;
                  w_state_nxt  = S_DONE;
               end else begin
                  w_cnt_nxt = r_cnt + 6'd1;
               end
            end
            S_DONE: begin
               // ex_start still belongs to the retiring instruction here
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath registers: iteration counter, accumulator, operands, result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= 6'd0;
         r_acc    <= 64'd0;
         r_opb    <= 32'd0;
         r_op     <= 3'd0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= 32'd0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_acc    <= w_acc_nxt;
         r_opb    <= w_opb_nxt;
         r_op     <= w_op_nxt;
         r_neg_q  <= w_neg_q_nxt;
         r_neg_r  <= w_neg_r_nxt;
         r_result <= w_result_nxt;
      end
   end

   assign muldiv_result = r_result;
   assign muldiv_valid  = (r_state == S_DONE) & ~flush;
   assign muldiv_stall  = rst & (((r_state == S_IDLE) & ex_start & ~flush) |
                                 (r_state == S_BUSY));

endmodule
`default_nettype wire
